// File: rtl/mem_copy_master_if.sv
// -----------------------------------------------------------------------------
// mem_copy_master_if
// Groups the request/status handshake of the block-copy engine together with
// the ren/wen word Memory port it drives.
//
//   Request side : start, src_addr, dst_addr, len
//   Status side  : busy, done, err, count
//   Memory side  : mem_ren, mem_wen, mem_addr, mem_din (to Memory),
//                  mem_dout (from Memory, combinational read data)
//
// Modports:
//   master - the copy engine (drives status and Memory controls)
//   slave  - the environment: requester plus Memory (drives request, mem_dout)
// -----------------------------------------------------------------------------
interface mem_copy_master_if #(
   parameter int AW = 10,
   parameter int LW = 11
);
   logic          start;
   logic [31:0]   src_addr;
   logic [31:0]   dst_addr;
   logic [LW-1:0] len;

   logic          busy;
   logic          done;
   logic          err;
   logic [LW-1:0] count;

   logic          mem_ren;
   logic          mem_wen;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_din;
   logic [31:0]   mem_dout;

   modport master (
      input  start, src_addr, dst_addr, len, mem_dout,
      output busy, done, err, count,
      output mem_ren, mem_wen, mem_addr, mem_din
   );

   modport slave (
      output start, src_addr, dst_addr, len, mem_dout,
      input  busy, done, err, count,
      input  mem_ren, mem_wen, mem_addr, mem_din
   );
endinterface

// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
// Bus initiator that copies LEN consecutive 32-bit words from a source word
// address to a destination word address on a level-sensitive ren/wen Memory.
// Each word is read, then written with a dedicated setup cycle (WSET), a
// one-cycle write pulse (WPUL) and a hold cycle (WHLD), so the combinational
// Memory never sees ren and wen together and never sees addr/din move while
// wen is high. Every word costs exactly four cycles.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high reset
//   bus    - mem_copy_master_if.master:
//              start/src_addr/dst_addr/len  request, sampled only in IDLE
//              busy                         CHECK..DONE inclusive
//              done                         one-cycle completion pulse
//              err                          qualifies done: request rejected
//              count                        words fully written so far
//              mem_ren/mem_wen/mem_addr/mem_din  Memory controls (registered)
//              mem_dout                     Memory read data
//
// Parameters:
//   AW - word-address bits honoured by Memory (2^AW words)
//   LW - width of the length field (holds up to 2^AW)
// -----------------------------------------------------------------------------
module mem_copy_master #(
   parameter int AW = 10,
   parameter int LW = 11
) (
   input  logic                clock,
   input  logic                reset,
   mem_copy_master_if.master   bus
);

   // Width for the end-of-range sums: wide enough for both operands plus a
   // carry, so src+len never wraps before being compared with 2^AW.
   localparam int SW = ((LW > AW) ? LW : AW) + 1;
   localparam logic [SW-1:0] LIMIT = SW'(1) << AW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_RD,
      S_WSET,
      S_WPUL,
      S_WHLD,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   src_q,   src_d;
   logic [31:0]   dst_q,   dst_d;
   logic [LW-1:0] len_q,   len_d;
   logic [LW-1:0] idx_q,   idx_d;
   logic [LW-1:0] count_q, count_d;
   logic [31:0]   buf_q,   buf_d;
   logic [31:0]   addr_q,  addr_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;
   logic          err_q,   err_d;
   logic          ren_q,   ren_d;
   logic          wen_q,   wen_d;

   // ---------------------------------------------------------------------------
   // Address and range arithmetic
   // ---------------------------------------------------------------------------
   logic [LW-1:0] idx_inc;
   logic [LW-1:0] rd_idx;
   logic [AW-1:0] rd_word;
   logic [AW-1:0] wr_word;
   logic [SW-1:0] src_end;
   logic [SW-1:0] dst_end;
   logic          req_bad;
   logic          last_word;

   assign idx_inc   = idx_q + LW'(1);
   assign last_word = (idx_inc == len_q);

   // The read address is loaded on the edge that enters RD: from CHECK that is
   // word 0 (idx_q is still 0), from WHLD it is the next word.
   assign rd_idx  = (state_q == S_WHLD) ? idx_inc : idx_q;
   assign rd_word = src_q[AW-1:0] + AW'(rd_idx);
   assign wr_word = dst_q[AW-1:0] + AW'(idx_q);

   assign src_end = SW'(src_q[AW-1:0]) + SW'(len_q);
   assign dst_end = SW'(dst_q[AW-1:0]) + SW'(len_q);

   // Any address bit above the Memory window, or a range that would run past
   // the last word, rejects the whole request before any access is made.
   assign req_bad = (src_q[31:AW] != '0) ||
                    (dst_q[31:AW] != '0) ||
                    (src_end > LIMIT)    ||
                    (dst_end > LIMIT);

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   // NOTE: every *_d gets its hold/default value first, so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      idx_d   = idx_q;
      count_d = count_q;
      buf_d   = buf_q;
      addr_d  = addr_q;
      busy_d  = busy_q;
      err_d   = err_q;
      done_d  = 1'b0;
      ren_d   = 1'b0;
      wen_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               src_d   = bus.src_addr;
               dst_d   = bus.dst_addr;
               len_d   = bus.len;
               idx_d   = '0;
               count_d = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            if (req_bad) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (len_q == '0) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               ren_d   = 1'b1;
               addr_d  = 32'(rd_word);
               state_d = S_RD;
            end
         end

         S_RD: begin
            // Read data is captured on the edge leaving RD; the buffer doubles
            // as the registered write-data output for the next three cycles.
            buf_d   = bus.mem_dout;
            addr_d  = 32'(wr_word);
            state_d = S_WSET;
         end

         S_WSET: begin
            wen_d   = 1'b1;
            state_d = S_WPUL;
         end

         S_WPUL: begin
            state_d = S_WHLD;
         end

         S_WHLD: begin
            count_d = count_q + LW'(1);
            if (last_word) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_inc;
               ren_d   = 1'b1;
               addr_d  = 32'(rd_word);
               state_d = S_RD;
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the read buffer and the latched request are datapath flops,
         // not a memory array, and are cleared so mem_din and the window check
         // never start from unknown values.
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         count_q <= '0;
         buf_q   <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         buf_q   <= buf_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: all straight from flops
   // ---------------------------------------------------------------------------
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.count    = count_q;
   assign bus.mem_ren  = ren_q;
   assign bus.mem_wen  = wen_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_din  = buf_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_master
// Self-checking bench for mem_copy_master: a behavioural word Memory, a table
// of copy requests with expected err/latency/count, a write scoreboard fed
// from a reference copy model, a protocol monitor, and hand-written sequences
// for the mid-transfer reset and the ignored start pulses.
// -----------------------------------------------------------------------------
module tb_mem_copy_master;

   localparam int AW    = 10;
   localparam int LW    = 11;
   localparam int DEPTH = 1 << AW;

   logic clock;
   logic reset;

   mem_copy_master_if #(.AW(AW), .LW(LW)) bus ();

   mem_copy_master #(.AW(AW), .LW(LW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------------------------------------------------------------------
   // Behavioural Memory: combinational read, write while wen is high at an edge
   // ---------------------------------------------------------------------------
   logic [31:0] mem   [DEPTH];
   logic [31:0] model [DEPTH];

   assign bus.mem_dout = mem[bus.mem_addr[AW-1:0]];

   always @(posedge clock) begin
      if (bus.mem_wen) mem[bus.mem_addr[AW-1:0]] <= bus.mem_din;
   end

   // ---------------------------------------------------------------------------
   // Check bookkeeping
   // ---------------------------------------------------------------------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Write scoreboard and protocol monitor
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t  sb_q[$];
   int   proto_viol = 0;
   int   ren_cnt    = 0;
   int   wen_cnt    = 0;
   logic prev_wen   = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_din  = '0;
   logic rst_at_edge = 1'b1;

   always @(posedge clock) rst_at_edge = reset;

   always @(negedge clock) begin
      wr_t e;
      if (bus.mem_ren && bus.mem_wen) proto_viol++;
      if (bus.mem_addr[31:AW] != '0)  proto_viol++;
      // A reset edge legitimately clears addr/din after a write pulse.
      if (!rst_at_edge && (bus.mem_wen || prev_wen) &&
          ((bus.mem_addr != prev_addr) || (bus.mem_din != prev_din)))
         proto_viol++;
      if (bus.mem_ren) ren_cnt++;
      if (bus.mem_wen) begin
         wen_cnt++;
         check("sb_write_expected", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_wr_addr", 64'(bus.mem_addr), 64'(e.addr));
            check("sb_wr_data", 64'(bus.mem_din),  64'(e.data));
         end
      end
      prev_wen  = bus.mem_wen;
      prev_addr = bus.mem_addr;
      prev_din  = bus.mem_din;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   typedef struct {
      string         name;
      logic [31:0]   src;
      logic [31:0]   dst;
      logic [LW-1:0] len;
      bit            poke;      // pulse start mid-transfer and during DONE
      bit            exp_err;
      int            exp_cyc;   // cycle (after the start edge) where done is high
   } vec_t;

   // Reference copy: ascending, read-then-write per word, so overlapping
   // ranges replicate exactly as the hardware does.
   task automatic model_copy(input logic [31:0] src, input logic [31:0] dst,
                             input int n);
      wr_t w;
      for (int i = 0; i < n; i++) begin
         w.addr = 32'((dst[AW-1:0] + i) % DEPTH);
         w.data = model[(src[AW-1:0] + i) % DEPTH];
         model[w.addr[AW-1:0]] = w.data;
         sb_q.push_back(w);
      end
   endtask

   task automatic check_image(input string name);
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== model[i]) bad++;
      check(name, 64'(bad), 64'd0);
   endtask

   task automatic issue(input logic [31:0] src, input logic [31:0] dst,
                        input logic [LW-1:0] len);
      @(negedge clock);
      bus.start    = 1'b1;
      bus.src_addr = src;
      bus.dst_addr = dst;
      bus.len      = len;
      @(negedge clock);
      bus.start    = 1'b0;
   endtask

   task automatic run_copy(input vec_t v);
      int cyc;
      int n_exp;
      n_exp   = v.exp_err ? 0 : int'(v.len);
      ren_cnt = 0;
      wen_cnt = 0;
      model_copy(v.src, v.dst, n_exp);
      issue(v.src, v.dst, v.len);
      cyc = 1;
      check({v.name, "_busy_c1"}, 64'(bus.busy), 64'd1);
      while (!bus.done && cyc < 5000) begin
         if (v.poke && cyc == 5) begin
            bus.start    = 1'b1;
            bus.src_addr = 32'h0;
            bus.dst_addr = 32'h300;
            bus.len      = LW'(5);
         end
         @(negedge clock);
         bus.start = 1'b0;
         cyc++;
      end
      check({v.name, "_done_seen"},  64'(bus.done), 64'd1);
      check({v.name, "_done_cycle"}, 64'(cyc),      64'(v.exp_cyc));
      check({v.name, "_err"},        64'(bus.err),  64'(v.exp_err));
      check({v.name, "_count"},      64'(bus.count), 64'(n_exp));
      if (v.poke) begin
         bus.start    = 1'b1;
         bus.src_addr = 32'h0;
         bus.dst_addr = 32'h300;
         bus.len      = LW'(5);
      end
      @(negedge clock);
      bus.start = 1'b0;
      check({v.name, "_busy_after"}, 64'(bus.busy), 64'd0);
      check({v.name, "_done_pulse"}, 64'(bus.done), 64'd0);
      @(negedge clock);
      check({v.name, "_idle_busy"},  64'(bus.busy), 64'd0);
      check({v.name, "_ren_cycles"}, 64'(ren_cnt),  64'(n_exp));
      check({v.name, "_wen_cycles"}, 64'(wen_cnt),  64'(n_exp));
      check({v.name, "_sb_empty"},   64'(sb_q.size()), 64'd0);
      check_image({v.name, "_mem_image"});
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   vec_t        vecs[10];
   logic [31:0] orig_104;
   logic [31:0] orig_tail[8];

   initial begin
      vecs[0] = '{"basic",      32'h10,        32'h100, LW'(4),    1'b0, 1'b0, 18};
      vecs[1] = '{"src_over",   32'h3FE,       32'h180, LW'(3),    1'b0, 1'b1, 2};
      vecs[2] = '{"src_edge",   32'h3FD,       32'h180, LW'(3),    1'b0, 1'b0, 14};
      vecs[3] = '{"dst_hi",     32'h30,        32'h400, LW'(1),    1'b0, 1'b1, 2};
      vecs[4] = '{"len_zero",   32'h5,         32'h9,   LW'(0),    1'b0, 1'b0, 2};
      vecs[5] = '{"overlap",    32'h20,        32'h21,  LW'(2),    1'b1, 1'b0, 10};
      vecs[6] = '{"src_hi",     32'h8000_0010, 32'h50,  LW'(1),    1'b0, 1'b1, 2};
      vecs[7] = '{"dst_last",   32'h60,        32'h3FF, LW'(1),    1'b0, 1'b0, 6};
      vecs[8] = '{"dst_over",   32'h60,        32'h3FF, LW'(2),    1'b0, 1'b1, 2};
      vecs[9] = '{"full_self",  32'h0,         32'h0,   LW'(1024), 1'b0, 1'b0, 4098};

      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[16'h10 + i] = 32'hA0A0_0000 + 32'(i);
      mem[16'h20] = 32'hDEAD;
      mem[16'h21] = 32'h1;
      for (int i = 0; i < DEPTH; i++) model[i] = mem[i];
      orig_104 = mem[16'h104];

      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.src_addr = '0;
      bus.dst_addr = '0;
      bus.len      = '0;
      repeat (3) @(negedge clock);
      check("rst_busy",  64'(bus.busy),     64'd0);
      check("rst_done",  64'(bus.done),     64'd0);
      check("rst_err",   64'(bus.err),      64'd0);
      check("rst_ren",   64'(bus.mem_ren),  64'd0);
      check("rst_wen",   64'(bus.mem_wen),  64'd0);
      check("rst_addr",  64'(bus.mem_addr), 64'd0);
      check("rst_din",   64'(bus.mem_din),  64'd0);
      check("rst_count", 64'(bus.count),    64'd0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_copy(vecs[i]);
         if (i == 0) check("basic_0x104_kept", 64'(mem[16'h104]), 64'(orig_104));
         if (i == 5) begin
            check("overlap_0x21", 64'(mem[16'h21]), 64'hDEAD);
            check("overlap_0x22", 64'(mem[16'h22]), 64'hDEAD);
         end
      end

      // Reset during the write pulse of the third word of an 8-word copy.
      begin
         int cyc;
         int bad;
         for (int i = 0; i < 8; i++) orig_tail[i] = mem[16'h140 + i];
         model_copy(32'h40, 32'h140, 3);
         issue(32'h40, 32'h140, LW'(8));
         cyc = 1;
         while (cyc < 12) begin
            @(negedge clock);
            cyc++;
         end
         check("rst_mid_in_wpul", 64'(bus.mem_wen), 64'd1);
         #1 reset = 1'b1;
         @(negedge clock);
         check("rst_mid_wen",   64'(bus.mem_wen), 64'd0);
         check("rst_mid_busy",  64'(bus.busy),    64'd0);
         check("rst_mid_count", 64'(bus.count),   64'd0);
         check("rst_mid_done",  64'(bus.done),    64'd0);
         reset = 1'b0;
         @(negedge clock);
         bad = 0;
         for (int i = 0; i < 2; i++)
            if (mem[16'h140 + i] !== mem[16'h40 + i]) bad++;
         check("rst_mid_written", 64'(bad), 64'd0);
         bad = 0;
         for (int i = 3; i < 8; i++)
            if (mem[16'h140 + i] !== orig_tail[i]) bad++;
         check("rst_mid_untouched", 64'(bad), 64'd0);
         check("rst_mid_sb_empty", 64'(sb_q.size()), 64'd0);
         check_image("rst_mid_mem_image");
      end

      run_copy('{"after_rst", 32'h40, 32'h140, LW'(8), 1'b0, 1'b0, 34});

      check("protocol_violations", 64'(proto_viol), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator for the level-sensitive ren/wen word Memory port.
- Copies LEN consecutive 32-bit words from a source word address to a destination word address, one word at a time.
- Sequences ren/wen with explicit setup and hold cycles so the combinational Memory never sees ren and wen high together, and never sees an address or data change while wen is high.
- Sits beside the multicycle datapath; it is used for program/data preload and block moves while the CPU FSM leaves the Memory port idle.

Parameters:
- AW, 10, word-index address bits honoured by Memory (addr[AW-1:0]).
- LW, 11, width of the length field (max LEN = 2^AW = 1024).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  first source word address.
- dst_addr  in  32  first destination word address.
- len  in  LW  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: request rejected, no memory access made.
- count  out  LW  words fully written so far in the current or last transfer.
- mem_ren  out  1  to Memory ren.
- mem_wen  out  1  to Memory wen.
- mem_addr  out  32  to Memory addr; bits [31:AW] are always 0.
- mem_din  out  32  to Memory din (write data).
- mem_dout  in  32  from Memory dout (read data, combinational).

Behaviour:
- Reset (sync): state=IDLE; busy, done, err, mem_ren, mem_wen = 0; mem_addr, mem_din, count = 0; internal read buffer = 0.
- Reset mid-transfer takes effect at the next edge. mem_wen drops in that cycle. Words already written stay in Memory; no completion pulse is produced.
- All outputs are registered. mem_ren and mem_wen are never 1 in the same cycle, in any state.
- States: IDLE, CHECK, RD, WSET, WPUL, WHLD, DONE.
- IDLE:
  - start=1 latches src_addr, dst_addr, len, clears count, then goes to CHECK.
  - start=0 stays in IDLE.
- CHECK (1 cycle, no memory access):
  - err is set if any of these holds: src_addr[31:AW]!=0; dst_addr[31:AW]!=0; src+len > 2^AW; dst+len > 2^AW. The sums use AW+1+ bits, so there is no wrap-around; the copy never wraps past address 2^AW-1.
  - err set -> DONE.
  - len==0 -> DONE with err=0, no memory access.
  - Otherwise -> RD.
- RD: mem_addr=src+i, mem_ren=1. mem_dout is captured into the buffer at the edge leaving RD. -> WSET.
- WSET: mem_ren=0, mem_addr=dst+i, mem_din=buffer, mem_wen=0. -> WPUL.
- WPUL: mem_wen=1; addr and din held. -> WHLD.
- WHLD: mem_wen=0; addr and din held. count increments at the exit edge. If i+1==len -> DONE, else i+1, then -> RD.
- Per-word cost is exactly 4 cycles (RD, WSET, WPUL, WHLD). Latency from start to done for len=N>0 is 1 + 1 + 4N cycles; done is high in cycle 2+4N after the start edge.
- DONE: done=1 for exactly one cycle; err holds its CHECK result for that cycle. busy=0 when DONE exits. -> IDLE. err clears on the next accepted start.
- Overlap: the copy is strictly ascending, with each word read and then written before the next read.
  - dst==src leaves memory unchanged.
  - dst==src+1 replicates mem[src] across the range; this is the required, defined behaviour.
- start asserted while not in IDLE (including in DONE) is ignored, not queued.
- In IDLE, CHECK and DONE: mem_ren=0, mem_wen=0; mem_addr and mem_din hold their last values.

Test Plan:
- Basic copy: mem[0x10..0x13]=A0,A1,A2,A3; start src=0x10 dst=0x100 len=4 -> mem[0x100..0x103]=A0..A3; done in cycle 18; count=4; err=0; mem[0x104] unchanged.
- Protocol check: monitor every cycle of the basic copy -> never (mem_ren & mem_wen); mem_addr and mem_din constant in each WSET/WPUL/WHLD triple; no Memory ERROR/WARNING messages printed.
- Bounds: src=0x3FE len=3 -> done and err in cycle 2, zero ren/wen pulses. src=0x3FD len=3 -> succeeds, last read at 0x3FF. dst=0x400 -> err.
- len=0: start src=5 dst=9 len=0 -> done in cycle 2, err=0, count=0, no memory activity.
- Overlap and ignore: mem[0x20]=0xDEAD, mem[0x21]=0x1; start src=0x20 dst=0x21 len=2 -> mem[0x21]=mem[0x22]=0xDEAD. A start pulsed mid-transfer has no effect.
- Reset mid-transfer: len=8, assert reset during the WPUL of word 3 -> next cycle mem_wen=0, busy=0, count=0; mem[dst+0..1] written, mem[dst+3..7] untouched; a subsequent start runs normally.
